// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one word fetch at a time to instruction memory and
// hands each returned word to decode over a valid/ready handshake, honouring redirects.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        redirect,
  input  logic [31:0] pc_target
);

  typedef enum logic [1:0] {StFetchReq, StWaitRsp, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] pc_out_q, pc_out_d;

  // Target is always word-aligned; the low bits are dropped on purpose.
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^pc_target[1:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_out_d      = pc_out_q;

    if (redirect) begin
      pc_d          = {pc_target[31:2], 2'b00};
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
      unique case (state_q)
        StFetchReq: begin
          // The old-PC request is already accepted; its response must be dropped.
          if (imem_req_ready) begin
            discard_d = 1'b1;
            state_d   = StWaitRsp;
          end
        end
        StWaitRsp: begin
          if (imem_rsp_valid) begin
            discard_d = 1'b0;
            state_d   = StFetchReq;
          end else begin
            discard_d = 1'b1;
          end
        end
        StHold:  state_d = StFetchReq;
        default: state_d = StFetchReq;
      endcase
    end else begin
      unique case (state_q)
        StFetchReq: begin
          if (imem_req_ready) begin
            state_d = StWaitRsp;
          end
        end
        StWaitRsp: begin
          if (imem_rsp_valid) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = StFetchReq;
            end else begin
              instr_d       = imem_rsp_data;
              pc_out_d      = pc_q;
              instr_valid_d = 1'b1;
              state_d       = StHold;
            end
          end
        end
        StHold: begin
          if (instr_ready) begin
            pc_d          = pc_q + 32'd4;
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            state_d       = StFetchReq;
          end
        end
        default: state_d = StFetchReq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetchReq;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      pc_out_q      <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_out_q      <= pc_out_d;
    end
  end

  assign imem_req_valid = (state_q == StFetchReq) && !reset;
  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc_out         = pc_out_q;
  assign pc_plus4       = pc_out_q + 32'd4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural memory with configurable latency, directed
// scenarios, and a randomized run checked against a program-order PC model.
module tb_instruction_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] instr;
  logic        instr_valid, instr_ready = 1'b1;
  logic [31:0] pc_out, pc_plus4;
  logic        redirect = 1'b0;
  logic [31:0] pc_target = '0;

  // Second instance for the wrap-around reset vector.
  logic        reset2 = 1'b1;
  logic        req_valid2, req_ready2 = 1'b1;
  logic [31:0] addr2;
  logic        rsp_valid2 = 1'b0;
  logic [31:0] rsp_data2 = '0;
  logic [31:0] instr2;
  logic        instr_valid2, instr_ready2 = 1'b0;
  logic [31:0] pc_out2, pc_plus4_2;

  int errors = 0;
  int checks = 0;

  // Memory model state.
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_lat = 0;
  int          lat_cfg = 0;

  always #5 clk = ~clk;

  instruction_fetch u_dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .redirect       (redirect),
    .pc_target      (pc_target)
  );

  instruction_fetch #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk            (clk),
    .reset          (reset2),
    .imem_req_valid (req_valid2),
    .imem_req_ready (req_ready2),
    .imem_addr      (addr2),
    .imem_rsp_valid (rsp_valid2),
    .imem_rsp_data  (rsp_data2),
    .instr          (instr2),
    .instr_valid    (instr_valid2),
    .instr_ready    (instr_ready2),
    .pc_out         (pc_out2),
    .pc_plus4       (pc_plus4_2),
    .redirect       (1'b0),
    .pc_target      (32'h0)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // One clock of the primary DUT with the memory model responding.
  task automatic advance();
    logic rv, qv, qr;
    logic [31:0] qa;
    imem_rsp_valid = mem_busy && (mem_lat == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;
    #1;
    rv = imem_rsp_valid;
    qv = imem_req_valid;
    qr = imem_req_ready;
    qa = imem_addr;
    @(posedge clk);
    if (rv) mem_busy = 1'b0;
    else if (mem_busy && mem_lat > 0) mem_lat--;
    if (qv && qr) begin
      mem_busy = 1'b1;
      mem_addr = qa;
      mem_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    end
    #1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      advance();
      n++;
    end
    checks++;
    if (!imem_req_valid) begin
      errors++;
      $display("FAIL %s: timeout waiting for imem_req_valid, got %0b want 1", name,
               imem_req_valid);
    end
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 20) begin
      advance();
      n++;
    end
    checks++;
    if (!instr_valid) begin
      errors++;
      $display("FAIL %s: timeout waiting for instr_valid, got %0b want 1", name, instr_valid);
    end
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    checks += 3;
    if (pc_out2 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_reset_pc: got %h want fffffffc", pc_out2);
    end
    if (pc_plus4_2 !== 32'h0) begin
      errors++; $display("FAIL wrap_reset_plus4: got %h want 00000000", pc_plus4_2);
    end
    if (instr_valid2 !== 1'b0) begin
      errors++; $display("FAIL wrap_reset_valid: got %0b want 0", instr_valid2);
    end
    reset2 = 1'b0;
    #1;
    checks++;
    if (req_valid2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first_req: got v=%0b a=%h want v=1 a=fffffffc",
                         req_valid2, addr2);
    end
    @(posedge clk); #1;
    rsp_valid2 = 1'b1;
    rsp_data2  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    rsp_valid2 = 1'b0;
    checks++;
    if (instr_valid2 !== 1'b1 || instr2 !== 32'hCAFE_F00D || pc_out2 !== 32'hFFFF_FFFC ||
        pc_plus4_2 !== 32'h0) begin
      errors++; $display("FAIL wrap_deliver: got v=%0b i=%h pc=%h p4=%h want 1 cafef00d fffffffc 0",
                         instr_valid2, instr2, pc_out2, pc_plus4_2);
    end
    instr_ready2 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_valid2 !== 1'b1 || addr2 !== 32'h0) begin
      errors++; $display("FAIL wrap_next_addr: got v=%0b a=%h want v=1 a=00000000",
                         req_valid2, addr2);
    end
    reset2 = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; lat_cfg = 0; imem_req_ready = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    advance();
    advance();
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== Nop ||
        pc_out !== 32'h0 || pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL reset_state: got rv=%0b iv=%0b i=%h pc=%h p4=%h want 0 0 %h 0 4",
                         imem_req_valid, instr_valid, instr, pc_out, pc_plus4, Nop);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] got[$];
    int first = -1;
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL seq_first_req: got v=%0b a=%h want v=1 a=0", imem_req_valid,
                         imem_addr);
    end
    for (int i = 0; i < 12; i++) begin
      advance();
      if (instr_valid) begin
        if (first < 0) first = i;
        got.push_back(pc_out);
        checks++;
        if (instr !== mem_word(pc_out)) begin
          errors++; $display("FAIL seq_data: got %h want %h", instr, mem_word(pc_out));
        end
      end
    end
    checks++;
    if (first != 1) begin
      errors++; $display("FAIL seq_latency: first valid after %0d clocks, want 2", first + 1);
    end
    checks++;
    if (got.size() < 3 || got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8) begin
      errors++; $display("FAIL seq_order: got %0d words, want pcs 0,4,8 in order", got.size());
    end
  endtask

  task automatic test_hold();
    logic [31:0] hpc, hin;
    instr_ready = 1'b0;
    wait_valid("hold_enter");
    hpc = pc_out;
    hin = instr;
    for (int i = 0; i < 5; i++) begin
      advance();
      checks++;
      if (instr_valid !== 1'b1 || pc_out !== hpc || instr !== hin || imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL hold_stable: got v=%0b pc=%h i=%h rv=%0b want 1 %h %h 0",
                           instr_valid, pc_out, instr, imem_req_valid, hpc, hin);
      end
    end
    instr_ready = 1'b1;
    advance();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== hpc + 32'd4) begin
      errors++; $display("FAIL hold_release: got v=%0b a=%h want v=1 a=%h", imem_req_valid,
                         imem_addr, hpc + 32'd4);
    end
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    wait_req("rdw_enter");
    lat_cfg = 2;
    advance();
    redirect = 1'b1; pc_target = 32'h0000_0102;
    advance();
    redirect = 1'b0;
    while (!imem_req_valid && n < 10) begin
      checks++;
      if (instr_valid !== 1'b0) begin
        errors++; $display("FAIL rdw_no_stale: got instr_valid=%0b pc=%h want 0", instr_valid,
                           pc_out);
      end
      advance();
      n++;
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL rdw_target: got v=%0b a=%h want v=1 a=00000100", imem_req_valid,
                         imem_addr);
    end
    lat_cfg = 0;
    wait_valid("rdw_new");
    checks++;
    if (pc_out !== 32'h100 || instr !== mem_word(32'h100)) begin
      errors++; $display("FAIL rdw_new_word: got pc=%h i=%h want 00000100 %h", pc_out, instr,
                         mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_edges();
    wait_req("rde_enter");
    lat_cfg = 0;
    advance();
    redirect = 1'b1; pc_target = 32'h0000_0200;
    advance();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL rde_rsp_same: got iv=%0b rv=%0b a=%h want 0 1 00000200",
                         instr_valid, imem_req_valid, imem_addr);
    end
    redirect = 1'b1; pc_target = 32'h0000_0304;
    advance();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rde_hs_same: got iv=%0b rv=%0b want 0 0", instr_valid,
                         imem_req_valid);
    end
    advance();
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h304) begin
      errors++; $display("FAIL rde_discard: got iv=%0b rv=%0b a=%h want 0 1 00000304",
                         instr_valid, imem_req_valid, imem_addr);
    end
    wait_valid("rde_new");
    checks++;
    if (pc_out !== 32'h304 || instr !== mem_word(32'h304)) begin
      errors++; $display("FAIL rde_new_word: got pc=%h i=%h want 00000304 %h", pc_out, instr,
                         mem_word(32'h304));
    end
  endtask

  task automatic test_reset_in_wait();
    wait_req("rst_enter");
    lat_cfg = 1;
    advance();
    reset = 1'b1;
    advance();
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wait_a: got iv=%0b rv=%0b want 0 0", instr_valid,
                         imem_req_valid);
    end
    advance();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL rst_wait_b: got iv=%0b want 0", instr_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL rst_restart: got rv=%0b a=%h iv=%0b want 1 0 0", imem_req_valid,
                         imem_addr, instr_valid);
    end
    lat_cfg = 0;
    wait_valid("rst_new");
    checks++;
    if (pc_out !== 32'h0 || instr !== mem_word(32'h0)) begin
      errors++; $display("FAIL rst_new_word: got pc=%h i=%h want 0 %h", pc_out, instr,
                         mem_word(32'h0));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int delivered = 0;
    reset = 1'b1; redirect = 1'b0;
    for (int i = 0; i < 5; i++) advance();
    mem_busy = 1'b0;
    reset = 1'b0;
    lat_cfg = -1;
    exp_pc = 32'h0;
    #1;
    for (int i = 0; i < 600; i++) begin
      checks++;
      if (instr_valid) begin
        if (pc_out !== exp_pc || instr !== mem_word(exp_pc) || pc_plus4 !== exp_pc + 32'd4) begin
          errors++; $display("FAIL rnd_deliver: got pc=%h i=%h p4=%h want %h %h %h", pc_out,
                             instr, pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
        end
      end else if (instr !== Nop) begin
        errors++; $display("FAIL rnd_nop: got %h want %h", instr, Nop);
      end
      if (imem_req_valid) begin
        checks++;
        if (imem_addr !== exp_pc || mem_busy) begin
          errors++; $display("FAIL rnd_req: got a=%h busy=%0b want a=%h busy=0", imem_addr,
                             mem_busy, exp_pc);
        end
      end
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = $urandom_range(0, 1) != 0;
      redirect       = ($urandom_range(0, 99) < 8);
      pc_target      = $urandom;
      if (redirect) exp_pc = {pc_target[31:2], 2'b00};
      else if (instr_valid && instr_ready) begin
        exp_pc += 32'd4;
        delivered++;
      end
      advance();
    end
    redirect = 1'b0;
    checks++;
    if (delivered < 20) begin
      errors++; $display("FAIL rnd_progress: got %0d delivered want >= 20", delivered);
    end
  endtask

  initial begin
    test_wrap();
    test_reset();
    test_sequential();
    test_hold();
    test_redirect_wait();
    test_redirect_edges();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
